// File: rtl/ram_copier_if.sv
// Single-port synchronous RAM bus as seen from the initiator (master) and the RAM (slave).
// data_out is registered: one cycle read latency, and it is not updated on write cycles.
interface ram_copier_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/ram_copier.sv
// Block copy / fill engine driving a single-port synchronous RAM.
// Copy alternates READ/WRITE per word; fill writes one word per cycle.
module ram_copier #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [15:0]       length,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [15:0]       words_done,
    ram_copier_if.master      mem
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state, state_n;
    logic              mode_r;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [15:0]       len_r;
    logic [DATA_W-1:0] fill_r;
    logic              accept;
    logic              last;

    // words_done doubles as the word index i: both clear at start and step on every WRITE.
    assign accept = (state == IDLE) && start;
    assign last   = ((words_done + 16'd1) == len_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            words_done <= '0;
        end else begin
            state <= state_n;
            if (accept)
                words_done <= '0;
            else if (state == WRITE)
                words_done <= words_done + 16'd1;
        end
    end

    // Command fields are pure data; they are only meaningful after an accepted start.
    always_ff @(posedge clk) begin
        if (accept) begin
            mode_r <= mode;
            src_r  <= src_addr;
            dst_r  <= dst_addr;
            len_r  <= length;
            fill_r <= fill_value;
        end
    end

    always_comb begin
        state_n       = state;
        busy          = 1'b0;
        done          = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        mem.mem_we    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length == 16'd0)
                        state_n = DONE;
                    else
                        state_n = mode ? WRITE : READ;
                end
            end
            READ: begin
                busy         = 1'b1;
                mem.mem_addr = src_r + words_done[ADDR_W-1:0];
                state_n      = abort ? IDLE : WRITE;
            end
            WRITE: begin
                busy          = 1'b1;
                mem.mem_addr  = dst_r + words_done[ADDR_W-1:0];
                mem.mem_we    = 1'b1;
                mem.mem_wdata = mode_r ? fill_r : mem.mem_rdata;
                if (abort)
                    state_n = IDLE;
                else if (last)
                    state_n = DONE;
                else
                    state_n = mode_r ? WRITE : READ;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_copier.sv
// Bench for ram_copier: behavioural RAM slave plus a write scoreboard fed by each scenario.
module tb_ram_copier;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [15:0]       length;
    logic [DATA_W-1:0] fill_value;
    logic              abort;
    logic              busy;
    logic              done;
    logic [15:0]       words_done;

    int checks;
    int errors;

    logic [DATA_W-1:0] ram     [DEPTH];
    logic [DATA_W-1:0] exp_mem [DEPTH];
    wr_t               exp_q[$];

    ram_copier_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_copier #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .fill_value (fill_value),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .words_done (words_done),
        .mem        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM slave: registered read, data_out frozen on write cycles.
    always @(posedge clk) begin
        if (bus.mem_we)
            ram[bus.mem_addr] <= bus.mem_wdata;
        else
            bus.mem_rdata <= ram[bus.mem_addr];
    end

    // Every RAM write must match the head of the expected-write queue.
    always @(negedge clk) begin
        if (rst_n && bus.mem_we === 1'b1) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%h, no write expected", bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (bus.mem_addr !== e.a || bus.mem_wdata !== e.d) begin
                    errors++;
                    $display("FAIL write addr=%0d data=%h, required addr=%0d data=%h",
                             bus.mem_addr, bus.mem_wdata, e.a, e.d);
                end
            end
        end
    end

    task automatic preload(input int addr, input logic [DATA_W-1:0] val);
        ram[addr]     = val;
        exp_mem[addr] = val;
    endtask

    task automatic push_copy(input int src, input int dst, input int n);
        for (int j = 0; j < n; j++) begin
            wr_t e;
            e.a = ADDR_W'((dst + j) % DEPTH);
            e.d = exp_mem[(src + j) % DEPTH];
            exp_mem[e.a] = e.d;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_fill(input int dst, input logic [DATA_W-1:0] val, input int n);
        for (int j = 0; j < n; j++) begin
            wr_t e;
            e.a = ADDR_W'((dst + j) % DEPTH);
            e.d = val;
            exp_mem[e.a] = val;
            exp_q.push_back(e);
        end
    endtask

    // Returns at 1 time unit after the accepting edge E0.
    task automatic do_start(input logic m, input int src, input int dst, input int len,
                            input logic [DATA_W-1:0] fv);
        @(posedge clk); #1;
        start      = 1'b1;
        mode       = m;
        src_addr   = ADDR_W'(src);
        dst_addr   = ADDR_W'(dst);
        length     = 16'(len);
        fill_value = fv;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_to_done(input int budget, output int n_busy, output int n_cyc, output bit got);
        n_busy = 0;
        n_cyc  = 0;
        got    = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            n_cyc++;
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (busy === 1'b1) n_busy++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || words_done !== 16'd0 || bus.mem_we !== 1'b0 ||
            bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b wd=%0d we=%b addr=%0d wdata=%h, required all 0",
                     busy, done, words_done, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
    endtask

    task automatic test_copy();
        int nb, nc;
        bit got;
        for (int j = 0; j < 4; j++) preload(100 + j, 16'hA000 + 16'(j));
        push_copy(100, 200, 4);
        do_start(1'b0, 100, 200, 4, 16'h0000);
        run_to_done(40, nb, nc, got);
        checks++;
        if (!got || nb !== 8 || nc !== 9) begin
            errors++;
            $display("FAIL copy_timing done=%0b busy_cycles=%0d done_cycle=%0d, required 1/8/9", got, nb, nc);
        end
        checks++;
        if (words_done !== 16'd4) begin
            errors++;
            $display("FAIL copy_words_done got %0d, required 4", words_done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL copy_done_width done=%b busy=%b after pulse, required 0/0", done, busy);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (ram[200 + j] !== 16'hA000 + 16'(j) || ram[100 + j] !== 16'hA000 + 16'(j)) begin
                errors++;
                $display("FAIL copy_ram[%0d] dst=%h src=%h, required %h", j, ram[200 + j], ram[100 + j],
                         16'hA000 + 16'(j));
            end
        end
    endtask

    task automatic test_fill_wrap();
        int nb, nc;
        bit got;
        push_fill(32766, 16'h5A5A, 4);
        do_start(1'b1, 0, 32766, 4, 16'h5A5A);
        run_to_done(40, nb, nc, got);
        checks++;
        if (!got || nb !== 4 || nc !== 5) begin
            errors++;
            $display("FAIL fill_timing done=%0b busy_cycles=%0d done_cycle=%0d, required 1/4/5", got, nb, nc);
        end
        checks++;
        if (ram[1] !== 16'h5A5A || ram[32767] !== 16'h5A5A || words_done !== 16'd4) begin
            errors++;
            $display("FAIL fill_wrap ram[1]=%h ram[32767]=%h wd=%0d, required 5a5a/5a5a/4", ram[1], ram[32767],
                     words_done);
        end
    endtask

    task automatic test_zero_length();
        int nb, nc;
        bit got;
        do_start(1'b0, 5, 6, 0, 16'h0000);
        run_to_done(10, nb, nc, got);
        checks++;
        if (!got || nb !== 0 || nc !== 1 || words_done !== 16'd0) begin
            errors++;
            $display("FAIL zero_length done=%0b busy_cycles=%0d done_cycle=%0d wd=%0d, required 1/0/1/0",
                     got, nb, nc, words_done);
        end
    endtask

    task automatic test_abort();
        for (int j = 0; j < 10; j++) preload(400 + j, 16'hC000 + 16'(j));
        preload(602, 16'hDEAD);
        push_copy(400, 600, 2);
        do_start(1'b0, 400, 600, 10, 16'h0000);
        repeat (4) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus.mem_we !== 1'b0 || words_done !== 16'd2) begin
            errors++;
            $display("FAIL abort_idle busy=%b we=%b wd=%0d, required 0/0/2", busy, bus.mem_we, words_done);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done done=%b busy=%b, required 0/0", done, busy);
            end
        end
        checks++;
        if (ram[602] !== 16'hDEAD || ram[601] !== 16'hC001 || words_done !== 16'd2) begin
            errors++;
            $display("FAIL abort_ram ram[601]=%h ram[602]=%h wd=%0d, required c001/dead/2", ram[601], ram[602],
                     words_done);
        end
    endtask

    task automatic test_reset_mid_fill();
        int nb, nc;
        bit got;
        push_fill(300, 16'h3C3C, 2);
        do_start(1'b1, 0, 300, 8, 16'h3C3C);
        repeat (2) begin @(posedge clk); #1; end
        #2;
        checks++;
        if (bus.mem_we !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_we got %b, required 1", bus.mem_we);
        end
        rst_n = 1'b0;
        #1;
        test_reset();
        @(posedge clk); #3;
        rst_n = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_writes pending=%0d, required 0", exp_q.size());
        end
        exp_q.delete();
        push_fill(310, 16'h7777, 1);
        do_start(1'b1, 0, 310, 1, 16'h7777);
        run_to_done(20, nb, nc, got);
        checks++;
        if (!got || nb !== 1 || nc !== 2 || words_done !== 16'd1) begin
            errors++;
            $display("FAIL reset_recover done=%0b busy_cycles=%0d done_cycle=%0d wd=%0d, required 1/1/2/1",
                     got, nb, nc, words_done);
        end
    endtask

    task automatic test_ignored_start_overlap();
        int nb, nc;
        bit got;
        preload(10, 16'h1111);
        for (int j = 11; j < 14; j++) preload(j, 16'h0000);
        push_copy(10, 11, 3);
        do_start(1'b0, 10, 11, 3, 16'h0000);
        @(posedge clk); #1;
        start      = 1'b1;
        mode       = 1'b1;
        dst_addr   = ADDR_W'(500);
        length     = 16'd2;
        fill_value = 16'hBEEF;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL overlap_busy got %b, required 1", busy);
        end
        @(posedge clk); #1;
        start = 1'b0;
        run_to_done(40, nb, nc, got);
        checks++;
        if (!got || nb !== 4 || nc !== 5 || words_done !== 16'd3) begin
            errors++;
            $display("FAIL overlap_timing done=%0b busy_rest=%0d done_cycle=%0d wd=%0d, required 1/4/5/3",
                     got, nb, nc, words_done);
        end
        for (int j = 11; j < 14; j++) begin
            checks++;
            if (ram[j] !== 16'h1111) begin
                errors++;
                $display("FAIL overlap_ram[%0d] got %h, required 1111", j, ram[j]);
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        mode       = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        length     = '0;
        fill_value = '0;
        abort      = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            ram[a]     = '0;
            exp_mem[a] = '0;
        end
        #13;
        test_reset();
        @(posedge clk); #3;
        rst_n = 1'b1;

        test_copy();
        test_fill_wrap();
        test_zero_length();
        test_abort();
        test_reset_mid_fill();
        test_ignored_start_overlap();

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes pending=%0d, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_copier.md
# ram_copier

Block-transfer engine that acts as the initiator on the single-port synchronous RAM interface (15-bit word address, 16-bit data, write_enable, registered data_out). On a start command it copies a run of words from a source to a destination region, or fills a region with a constant. It drives the RAM port directly and respects its one-cycle read latency. It also respects the RAM rule that data_out is not updated on write cycles. It sits between the control/CPU side and the RAM, so bulk moves proceed without per-word software traffic.

## Interface
Parameters:
- ADDR_W, 15, RAM word-address width (32Ki words)
- DATA_W, 16, RAM word width

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  command strobe, sampled only in IDLE
- mode  input  1  0 = copy, 1 = fill; latched at start
- src_addr  input  ADDR_W  copy source base; latched at start
- dst_addr  input  ADDR_W  destination base; latched at start
- length  input  16  word count, 0..32768; latched at start
- fill_value  input  DATA_W  fill word; latched at start
- abort  input  1  synchronous cancel of an active transfer
- busy  output  1  high while a transfer is active
- done  output  1  one-cycle pulse on normal completion
- words_done  output  16  count of words written in the current or last transfer
- mem_addr  output  ADDR_W  to RAM address
- mem_wdata  output  DATA_W  to RAM data
- mem_we  output  1  to RAM write_enable
- mem_rdata  input  DATA_W  from RAM data_out

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - mem_we = 0 and mem_addr = 0.
  - When start = 1, latch the command fields, clear words_done and index i.
  - If length == 0, go to DONE.
  - Otherwise go to READ if mode = 0, or WRITE if mode = 1.
- READ (copy only): mem_addr = src + i, mem_we = 0. Next state is WRITE.
- WRITE:
  - mem_addr = dst + i, mem_we = 1.
  - mem_wdata = mem_rdata (copy) or fill_value (fill). In copy mode this is a combinational pass-through of the word returned for the preceding READ cycle.
  - On the edge ending WRITE, i and words_done increment.
  - If i+1 == length, go to DONE. Otherwise go to READ (copy) or stay in WRITE (fill).
- DONE: done = 1 for exactly one cycle, busy = 0, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_W: src + i and dst + i wrap from 32767 to 0.
- Copy order is always ascending. Overlapping regions with dst > src propagate already-copied data; this is the defined behaviour, and no memmove semantics are provided.
- start while busy is ignored. start and abort in the same IDLE cycle: start wins, because abort is ignored in IDLE.
- abort in READ or WRITE:
  - Return to IDLE on the next edge with no done pulse. mem_we = 0 from the next cycle.
  - A WRITE in progress during the abort cycle still completes and is counted. words_done holds.
- words_done holds its final value after DONE/abort until the next accepted start.
- mem_wdata is 0 in non-WRITE states.

## Timing
- Reset (rst_n low, asynchronous): state IDLE; busy, done, mem_we, mem_addr, mem_wdata and words_done all 0. Assertion mid-transfer deasserts mem_we immediately, without waiting for a clock edge.
- start accepted at edge E0. busy is high from the cycle after E0.
- Copy of N ≥ 1 words: busy high for 2N cycles, with READ/WRITE alternating. done is high in cycle 2N+1, with busy low.
- Fill of N ≥ 1 words: busy high for N cycles, one write per cycle. done is high in cycle N+1.
- length == 0: no RAM access and busy never rises. done is high in the cycle after E0.
- Read latency: the word addressed in a READ cycle is valid on mem_rdata throughout the following WRITE cycle. No other read assumption is permitted.
- A new start is accepted in the cycle after DONE, which is IDLE.

## Test plan
- Copy:
  - Stimulus: preload RAM[100..103] = 0xA000..0xA003; start mode=0 src=100 dst=200 length=4.
  - Response: busy for 8 cycles, done in cycle 9, words_done=4, RAM[200..203] = 0xA000..0xA003, RAM[100..103] unchanged.
- Fill with wrap:
  - Stimulus: start mode=1 dst=32766 length=4 fill_value=0x5A5A.
  - Response: writes at 32766, 32767, 0, 1 on consecutive cycles; done in cycle 5.
- Zero length:
  - Stimulus: start length=0.
  - Response: mem_we never asserted, busy stays 0, done pulses one cycle after start.
- Abort mid-copy:
  - Stimulus: length=10, assert abort in the 5th busy cycle (READ of word 2).
  - Response: idle next cycle, no done, words_done=2, only dst+0 and dst+1 written.
- Reset mid-fill:
  - Stimulus: drop rst_n during a WRITE.
  - Response: mem_we falls without a clock edge; all outputs 0. After release, a start with length=1 runs normally.
- Ignored start and overlap:
  - Stimulus: pulse start while busy, with src=10 dst=11 length=3 and RAM[10]=0x1111.
  - Response: the second start has no effect, and RAM[11..13] = 0x1111 (forward propagation).
